// File: rtl/pp_dma_pkg.sv
// Shared types and constants for the SD-to-memory DMA engine.
//   state_t      : FSM state encoding (ST_IDLE .. ST_ERR)
//   BLOCK_WORDS  : words per SD block at the default block size
//   WCNT_W       : width of the per-block word counter
package pp_dma_pkg;

    localparam int unsigned DEF_BLOCK_BYTES = 512;
    localparam int unsigned BLOCK_WORDS     = DEF_BLOCK_BYTES / 4;
    localparam int unsigned WCNT_W          = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CMD  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_MEMW = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

    // Words per block for an arbitrary (multiple-of-4) block size.
    function automatic logic [WCNT_W-1:0] block_words(input int unsigned bytes);
        return WCNT_W'(bytes / 4);
    endfunction

endpackage

// File: rtl/pp_dma_packer.sv
// Byte-to-word packer: places each written byte into lane idx of a 32-bit
// little-endian word; first byte of a word lands in [7:0].
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   clr       : return byte index to lane 0
//   wr_en     : accept din this cycle
//   din       : data byte
//   word_c    : current word with din merged into the active lane
//   full_c    : wr_en on lane 3 (word completes this cycle)
module pp_dma_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [7:0]  din,
    output logic [31:0] word_c,
    output logic        full_c
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;

    // Lane insert
    always_comb begin
        word_c = word_q;
        case (idx_q)
            2'd0:    word_c[7:0]   = din;
            2'd1:    word_c[15:8]  = din;
            2'd2:    word_c[23:16] = din;
            default: word_c[31:24] = din;
        endcase
    end

    assign full_c = wr_en && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q <= 32'd0;
            idx_q  <= 2'd0;
        end else if (clr) begin
            idx_q  <= 2'd0;
        end else if (wr_en) begin
            word_q <= word_c;
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/pp_sd_dma.sv
// SD-to-memory DMA engine: on a rising edge of dma_en[0] reads sd_counts
// consecutive SD blocks starting at sd_addr, packs the byte stream into
// little-endian words and writes them to consecutive word addresses from
// dest_addr.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   sd_addr/sd_counts/dest_addr    : transfer registers, latched at start
//   dma_en                         : bit0 enable/start
//   sd_rd_req/sd_rd_addr/sd_rd_ack : block read command handshake
//   sd_rd_err                      : SD error strobe
//   sd_data/valid/ready            : byte stream from the SD controller
//   mem_wr/mem_addr/mem_wdata/mem_ready : memory write port
//   dma_busy/dma_done/dma_err/blocks_done : status
// Optional feature: define SD_DMA_TIMEOUT_EN for a CMD/DATA watchdog.
module pp_sd_dma
    import pp_dma_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES    = DEF_BLOCK_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sd_addr,
    input  logic [31:0] sd_counts,
    input  logic [31:0] dest_addr,
    input  logic [31:0] dma_en,
    output logic        sd_rd_req,
    output logic [31:0] sd_rd_addr,
    input  logic        sd_rd_ack,
    input  logic        sd_rd_err,
    input  logic [7:0]  sd_data,
    input  logic        sd_data_valid,
    output logic        sd_data_ready,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        dma_busy,
    output logic        dma_done,
    output logic        dma_err,
    output logic [31:0] blocks_done
);

    localparam logic [WCNT_W-1:0] BWORDS = block_words(BLOCK_BYTES);

    state_t            state_q, state_d;
    logic              en_q;
    logic [31:0]       sd_base_q;
    logic [31:0]       cnt_q;
    logic [WCNT_W-1:0] wcnt_q;

    logic              start_c;
    logic              accept_c;
    logic              blk_last_c;
    logic [31:0]       bd_inc_c;
    logic              timeout_c;
    logic              pk_clr_c;
    logic [31:0]       pk_word_c;
    logic              pk_full_c;

    assign start_c    = dma_en[0] && !en_q;
    assign accept_c   = (state_q == ST_DATA) && sd_data_ready && sd_data_valid;
    assign blk_last_c = (wcnt_q == BWORDS - WCNT_W'(1));
    assign bd_inc_c   = blocks_done + 32'd1;
    // Packer restarts at lane 0 whenever we are outside the data/write loop
    assign pk_clr_c   = (state_q != ST_DATA) && (state_q != ST_MEMW);

    pp_dma_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr    (pk_clr_c),
        .wr_en  (accept_c),
        .din    (sd_data),
        .word_c (pk_word_c),
        .full_c (pk_full_c)
    );

`ifdef SD_DMA_TIMEOUT_EN
    // Watchdog: counts stalled cycles in CMD/DATA, restarts on any handshake
    logic [31:0] wd_q;
    logic        wd_run_c;
    logic        wd_hs_c;
    logic        unused_c;

    assign wd_run_c  = (state_q == ST_CMD) || (state_q == ST_DATA);
    assign wd_hs_c   = ((state_q == ST_CMD) && sd_rd_ack) || accept_c;
    assign timeout_c = wd_run_c && !wd_hs_c && (wd_q >= 32'(TIMEOUT_CYCLES) - 32'd1);
    assign unused_c  = ^{dma_en[31:1], dest_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q <= 32'd0;
        end else if (!wd_run_c || wd_hs_c) begin
            wd_q <= 32'd0;
        end else begin
            wd_q <= wd_q + 32'd1;
        end
    end
`else
    logic unused_c;

    assign timeout_c = 1'b0;
    assign unused_c  = ^{dma_en[31:1], dest_addr[1:0], 32'(TIMEOUT_CYCLES)};
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) state_d = (sd_counts == 32'd0) ? ST_DONE : ST_CMD;
            end
            ST_CMD: begin
                if (sd_rd_err || timeout_c) state_d = ST_ERR;
                else if (!dma_en[0])        state_d = ST_IDLE;
                else if (sd_rd_ack)         state_d = ST_DATA;
            end
            ST_DATA: begin
                if (sd_rd_err || timeout_c) state_d = ST_ERR;
                else if (!dma_en[0])        state_d = ST_IDLE;
                else if (pk_full_c)         state_d = ST_MEMW;
            end
            ST_MEMW: begin
                if (mem_ready) begin
                    if (!dma_en[0])             state_d = ST_IDLE;
                    else if (!blk_last_c)       state_d = ST_DATA;
                    else if (bd_inc_c == cnt_q) state_d = ST_DONE;
                    else                        state_d = ST_CMD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs (decoded from next state)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            en_q          <= 1'b0;
            sd_base_q     <= 32'd0;
            cnt_q         <= 32'd0;
            wcnt_q        <= '0;
            sd_rd_req     <= 1'b0;
            sd_rd_addr    <= 32'd0;
            sd_data_ready <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            dma_busy      <= 1'b0;
            dma_done      <= 1'b0;
            dma_err       <= 1'b0;
            blocks_done   <= 32'd0;
        end else begin
            state_q       <= state_d;
            en_q          <= dma_en[0];
            sd_rd_req     <= (state_d == ST_CMD);
            sd_data_ready <= (state_d == ST_DATA);
            mem_wr        <= (state_d == ST_MEMW);
            dma_busy      <= (state_d != ST_IDLE);
            dma_done      <= (state_d == ST_DONE);
            if (state_d == ST_ERR) dma_err <= 1'b1;

            if ((state_q == ST_IDLE) && start_c) begin
                sd_base_q   <= sd_addr;
                cnt_q       <= sd_counts;
                sd_rd_addr  <= sd_addr;
                mem_addr    <= {dest_addr[31:2], 2'b00};
                wcnt_q      <= '0;
                blocks_done <= 32'd0;
                dma_err     <= 1'b0;
            end

            if ((state_q == ST_DATA) && (state_d == ST_MEMW)) mem_wdata <= pk_word_c;

            if ((state_q == ST_MEMW) && mem_ready) begin
                mem_addr <= mem_addr + 32'd4;
                if (blk_last_c) begin
                    wcnt_q      <= '0;
                    blocks_done <= bd_inc_c;
                    sd_rd_addr  <= sd_base_q + bd_inc_c;
                end else begin
                    wcnt_q      <= wcnt_q + WCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pp_sd_dma.sv
// Directed self-checking bench for pp_sd_dma with an SD responder, a memory
// model and a write scoreboard fed from the bytes the responder hands over.
module tb_pp_sd_dma;

    logic        clk;
    logic        rst;
    logic [31:0] sd_addr, sd_counts, dest_addr, dma_en;
    logic        sd_rd_req, sd_rd_ack, sd_rd_err;
    logic [31:0] sd_rd_addr;
    logic [7:0]  sd_data;
    logic        sd_data_valid, sd_data_ready;
    logic        mem_wr, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic        dma_busy, dma_done, dma_err;
    logic [31:0] blocks_done;

    pp_sd_dma #(.BLOCK_BYTES(512), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .sd_addr(sd_addr), .sd_counts(sd_counts), .dest_addr(dest_addr), .dma_en(dma_en),
        .sd_rd_req(sd_rd_req), .sd_rd_addr(sd_rd_addr), .sd_rd_ack(sd_rd_ack), .sd_rd_err(sd_rd_err),
        .sd_data(sd_data), .sd_data_valid(sd_data_valid), .sd_data_ready(sd_data_ready),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err), .blocks_done(blocks_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Model controls and monitors
    int          mem_wait = 0;
    bit          mem_hold = 0;
    bit          valid_rand = 0;
    bit          ack_block = 0;
    int          err_after = 0;
    bit          stream_stop = 0;
    logic [31:0] exp_blk = 0;
    logic [31:0] exp_addr = 0;
    logic [7:0]  byte_val = 0;
    logic [31:0] pack_word = 0;
    int          pack_n = 0;
    int          blk_bytes = 0;
    int          ack_wait = 0;
    int          mem_wcnt = 0;
    int          writes = 0, acks = 0, done_cnt = 0, req_cycles = 0;
    bit          first_flag = 0;
    logic [31:0] first_addr = 0, first_data = 0, last_addr = 0;
    int          w0, a0, d0, r0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // SD responder, memory model and monitors, all acting on the falling edge
    initial begin
        sd_rd_ack = 0; sd_rd_err = 0; sd_data = 0; sd_data_valid = 0; mem_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst) continue;
            if (dma_done) done_cnt++;
            if (sd_rd_req) req_cycles++;

            if (sd_rd_ack) sd_rd_ack = 0;
            else if (sd_rd_req && !ack_block) begin
                if (ack_wait < 2) ack_wait++;
                else begin
                    ack_wait = 0;
                    sd_rd_ack = 1;
                    check("sd_rd_addr", sd_rd_addr, exp_blk);
                    exp_blk = exp_blk + 32'd1;
                    acks++;
                    blk_bytes = 0;
                end
            end

            if (sd_rd_err) sd_rd_err = 0;
            sd_data_valid = !stream_stop && (!valid_rand || ($urandom_range(0, 1) == 1));
            if (err_after != 0 && blk_bytes == err_after && !stream_stop) begin
                sd_rd_err = 1;
                stream_stop = 1;
                sd_data_valid = 0;
            end
            sd_data = byte_val;
            if (sd_data_valid && sd_data_ready) begin
                pack_word[8*pack_n +: 8] = byte_val;
                pack_n++;
                byte_val = byte_val + 8'd1;
                blk_bytes++;
                if (pack_n == 4) begin
                    sb_q.push_back('{a: exp_addr, d: pack_word});
                    exp_addr = exp_addr + 32'd4;
                    pack_n = 0;
                end
            end

            if (mem_wr) begin
                if (mem_hold || mem_wcnt < mem_wait) begin
                    mem_ready = 0;
                    if (!mem_hold) mem_wcnt++;
                end else begin
                    mem_ready = 1;
                    mem_wcnt = 0;
                    writes++;
                    if (first_flag) begin
                        first_addr = mem_addr;
                        first_data = mem_wdata;
                        first_flag = 0;
                    end
                    last_addr = mem_addr;
                    if (sb_q.size() == 0) check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                    else begin
                        wr_t e;
                        e = sb_q.pop_front();
                        check("wr_addr", mem_addr, e.a);
                        check("wr_data", mem_wdata, e.d);
                    end
                end
            end else mem_ready = 0;
        end
    end

    task automatic start_xfer(input logic [31:0] sa, input logic [31:0] cnt, input logic [31:0] da);
        dma_en = 0;
        @(negedge clk);
        sd_addr = sa; sd_counts = cnt; dest_addr = da;
        exp_blk = sa; exp_addr = {da[31:2], 2'b00};
        pack_n = 0; byte_val = 0; stream_stop = 0; first_flag = 1; ack_wait = 0;
        w0 = writes; a0 = acks; d0 = done_cnt; r0 = req_cycles;
        @(negedge clk);
        dma_en = 32'h1;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            @(negedge clk);
        end
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    initial begin
        int lat;
        int wp;
        rst = 0; dma_en = 0; sd_addr = 0; sd_counts = 0; dest_addr = 0;
        repeat (3) @(negedge clk);
        check("rst_sd_rd_req", 32'(sd_rd_req), 0);
        check("rst_sd_rd_addr", sd_rd_addr, 0);
        check("rst_sd_data_ready", 32'(sd_data_ready), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_dma_busy", 32'(dma_busy), 0);
        check("rst_dma_done", 32'(dma_done), 0);
        check("rst_dma_err", 32'(dma_err), 0);
        check("rst_blocks_done", blocks_done, 0);
        rst = 1;
        repeat (2) @(negedge clk);

        // One block, zero-wait memory
        start_xfer(32'h10, 32'd1, 32'h2000);
        @(negedge clk);
        check("req_after_start", 32'(sd_rd_req), 1);
        check("busy_after_start", 32'(dma_busy), 1);
        wait_done(d0 + 1, 3000, "t1_done");
        repeat (3) @(negedge clk);
        check("t1_writes", 32'(writes - w0), 128);
        check("t1_first_addr", first_addr, 32'h2000);
        check("t1_first_data", first_data, 32'h0302_0100);
        check("t1_last_addr", last_addr, 32'h21FC);
        check("t1_done_pulses", 32'(done_cnt - d0), 1);
        check("t1_blocks_done", blocks_done, 1);
        check("t1_acks", 32'(acks - a0), 1);
        check("t1_sb_empty", 32'(sb_q.size()), 0);
        check("t1_idle", 32'(dma_busy), 0);

        // Two blocks, memory stalls and random byte valid
        mem_wait = 3; valid_rand = 1;
        start_xfer(32'h10, 32'd2, 32'h2000);
        wait_done(d0 + 1, 12000, "t2_done");
        repeat (3) @(negedge clk);
        check("t2_writes", 32'(writes - w0), 256);
        check("t2_acks", 32'(acks - a0), 2);
        check("t2_last_addr", last_addr, 32'h23FC);
        check("t2_blocks_done", blocks_done, 2);
        check("t2_done_pulses", 32'(done_cnt - d0), 1);
        check("t2_sb_empty", 32'(sb_q.size()), 0);
        mem_wait = 0; valid_rand = 0;

        // Zero block count
        start_xfer(32'h10, 32'd0, 32'h2000);
        lat = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (dma_done && lat == 0) lat = i;
        end
        check("t3_done_latency_ok", 32'((lat >= 1) && (lat <= 3)), 1);
        check("t3_done_pulses", 32'(done_cnt - d0), 1);
        check("t3_no_req", 32'(req_cycles - r0), 0);
        check("t3_no_writes", 32'(writes - w0), 0);
        check("t3_blocks_done", blocks_done, 0);

        // Abort while a write is stalled
        start_xfer(32'h10, 32'd1, 32'h2000);
        for (int i = 0; i < 1000; i++) begin
            if (writes - w0 >= 5) break;
            @(negedge clk);
        end
        check("t4_some_writes", 32'(writes - w0 >= 5), 1);
        mem_hold = 1;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (mem_wr === 1'b1) break;
            @(negedge clk);
        end
        check("t4_write_held", 32'(mem_wr), 1);
        dma_en = 0;
        repeat (4) @(negedge clk);
        check("t4_write_pending", 32'(mem_wr), 1);
        check("t4_busy_pending", 32'(dma_busy), 1);
        wp = writes;
        mem_hold = 0;
        repeat (4) @(negedge clk);
        check("t4_pending_completed", 32'(writes - wp), 1);
        check("t4_idle", 32'(dma_busy), 0);
        check("t4_no_mem_wr", 32'(mem_wr), 0);
        check("t4_no_ready", 32'(sd_data_ready), 0);
        check("t4_no_done", 32'(done_cnt - d0), 0);
        check("t4_blocks_done", blocks_done, 0);
        check("t4_sb_empty", 32'(sb_q.size()), 0);
        start_xfer(32'h10, 32'd1, 32'h2000);
        wait_done(d0 + 1, 3000, "t4_restart_done");
        repeat (3) @(negedge clk);
        check("t4_restart_writes", 32'(writes - w0), 128);
        check("t4_restart_first_addr", first_addr, 32'h2000);
        check("t4_restart_blocks", blocks_done, 1);

        // SD error after 10 bytes
        err_after = 10;
        start_xfer(32'h40, 32'd1, 32'h8000);
        for (int i = 0; i < 500; i++) begin
            if (dma_err === 1'b1) break;
            @(negedge clk);
        end
        check("t5_err_set", 32'(dma_err), 1);
        repeat (3) @(negedge clk);
        check("t5_idle", 32'(dma_busy), 0);
        check("t5_err_sticky", 32'(dma_err), 1);
        check("t5_writes", 32'(writes - w0), 2);
        check("t5_no_done", 32'(done_cnt - d0), 0);
        repeat (20) @(negedge clk);
        check("t5_no_more_writes", 32'(writes - w0), 2);
        err_after = 0;
        sb_q.delete();
        start_xfer(32'h40, 32'd0, 32'h8000);
        repeat (2) @(negedge clk);
        check("t5_err_cleared", 32'(dma_err), 0);
        repeat (3) @(negedge clk);

`ifdef SD_DMA_TIMEOUT_EN
        // Watchdog with the SD controller never acknowledging
        ack_block = 1;
        start_xfer(32'h10, 32'd1, 32'h2000);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (dma_err === 1'b1) begin lat = i; break; end
        end
        check("t6_timeout_window", 32'((lat >= 100) && (lat <= 103)), 1);
        ack_block = 0;
        repeat (3) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
